// File: rtl/dot_product.sv
// Two-stage pipelined signed dot product: stage 1 registers the element-wise
// products, stage 2 reduces them with a balanced adder tree into the output.
module dot_product #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    input  logic signed [DATA_WIDTH-1:0]       x [N],
    input  logic signed [DATA_WIDTH-1:0]       w [N],
    output logic                               out_valid,
    output logic signed [ACC_WIDTH-1:0]        out
);

    localparam int PW     = 2 * DATA_WIDTH;
    localparam int LEVELS = (N > 1) ? $clog2(N) : 0;

    // Number of live operands at a given tree level (odd ones pass through).
    function automatic int levelCount(input int lvl);
        int c;
        c = N;
        for (int k = 0; k < lvl; k++) c = (c + 1) / 2;
        return c;
    endfunction

    logic signed [PW-1:0]        prodReg [N];
    logic                        validS1;
    logic signed [ACC_WIDTH-1:0] tree [LEVELS+1][N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) prodReg[i] <= '0;
            validS1 <= 1'b0;
        end else begin
            validS1 <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < N; i++)
                    prodReg[i] <= PW'(x[i]) * PW'(w[i]);
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_leaf
        assign tree[0][i] = ACC_WIDTH'(prodReg[i]);
    end

    // Slots beyond a level's live operand count are tied to zero and never read.
    for (genvar l = 1; l <= LEVELS; l++) begin : g_level
        localparam int PREV = levelCount(l - 1);
        for (genvar i = 0; i < N; i++) begin : g_node
            if (i < PREV / 2) begin : g_add
                assign tree[l][i] = tree[l-1][2*i] + tree[l-1][2*i+1];
            end else if ((i == PREV / 2) && (PREV % 2 == 1)) begin : g_pass
                assign tree[l][i] = tree[l-1][PREV-1];
            end else begin : g_zero
                assign tree[l][i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= validS1;
            if (validS1) out <= tree[LEVELS][0];
        end
    end

endmodule

// File: tb/tb_dot_product.sv
// Scoreboard bench for dot_product: directed vectors push hand-computed results,
// a monitor pops and compares value and arrival cycle whenever out_valid is high.
module tb_dot_product;

    typedef logic signed [7:0] vecT [4];
    typedef struct {
        int val;
        int cyc;
    } expT;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic signed [7:0]   x [4];
    logic signed [7:0]   w [4];
    logic                out_valid;
    logic signed [31:0]  out;

    int  testsRun;
    int  testsFailed;
    int  cyc;
    int  lastVal;
    expT sbq [$];

    dot_product #(.N(4), .DATA_WIDTH(8), .ACC_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .x        (x),
        .w        (w),
        .out_valid(out_valid),
        .out      (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vecT xv, input vecT wv, input int expected);
        expT e;
        @(negedge clk);
        in_valid = 1'b1;
        x = xv;
        w = wv;
        e.val = expected;
        e.cyc = cyc + 2;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Monitor: pops on out_valid, flags late/missing results, checks hold value otherwise.
    initial begin
        expT e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (out_valid) begin
                    if (sbq.size() == 0) begin
                        checkOutput("unexpected out_valid", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        checkOutput("result value", out, e.val);
                        checkOutput("result cycle", cyc, e.cyc);
                        lastVal = e.val;
                    end
                end else begin
                    if (sbq.size() > 0 && cyc >= sbq[0].cyc) begin
                        e = sbq.pop_front();
                        checkOutput("missing result", cyc, e.cyc - 1);
                    end
                    checkOutput("hold value", out, lastVal);
                end
            end
        end
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        lastVal     = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x[i] = '0;
            w[i] = '0;
        end
        #3;
        checkOutput("reset out", out, 0);
        checkOutput("reset out_valid", int'(out_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        applyStimulus('{1, 2, 3, 4}, '{5, 6, 7, 8}, 70);
        idle(4);
        applyStimulus('{-1, -2, 3, 4}, '{5, 6, -7, 8}, -6);
        idle(3);
        applyStimulus('{-128, -128, -128, -128}, '{-128, -128, -128, -128}, 65536);
        applyStimulus('{-128, -128, -128, -128}, '{127, 127, 127, 127}, -65024);
        idle(3);

        applyStimulus('{1, 1, 1, 1}, '{1, 1, 1, 1}, 4);
        applyStimulus('{0, 0, 0, 0}, '{9, 9, 9, 9}, 0);
        applyStimulus('{2, 0, 0, 0}, '{3, 0, 0, 0}, 6);
        idle(4);

        // Reset while a result is in stage 1; out currently holds 6.
        applyStimulus('{1, 1, 1, 1}, '{2, 2, 2, 2}, 8);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sbq.delete();
        lastVal  = 0;
        #1;
        checkOutput("async reset out", out, 0);
        checkOutput("async reset out_valid", int'(out_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        checkOutput("no stale result", out, 0);

        applyStimulus('{1, 2, 3, 4}, '{1, 1, 1, 1}, 10);
        idle(2);
        applyStimulus('{0, 0, 0, 0}, '{5, 5, 5, 5}, 0);
        idle(5);

        checkOutput("scoreboard drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dot_product.md
Name: dot_product

Overview:
- Pipelined signed dot-product engine: computes sum over i of x[i]*w[i] for two N-element vectors.
- Used as the multiply-accumulate core of NPU processing elements.
- Accepts one vector pair per clock when in_valid is high.
- Produces the result a fixed 2 cycles later with out_valid.

Parameters:
- N, 4, vector dimensionality; must be >= 1; any value, not restricted to powers of two.
- DATA_WIDTH, 8, width of each signed element of x and w.
- ACC_WIDTH, 32, width of the signed result; must be >= 2*DATA_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  x and w hold a valid vector pair this cycle.
- x  input  N x DATA_WIDTH (unpacked array [N], signed)  activation vector.
- w  input  N x DATA_WIDTH (unpacked array [N], signed)  weight vector.
- out_valid  output  1  out holds a valid result this cycle.
- out  output  ACC_WIDTH signed  dot-product result.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset:
  - While rst_n is low, all pipeline registers clear, out = 0 and out_valid = 0, independent of clk.
  - Release is sampled on the next rising clk edge.
- Stage 1 (on the edge where in_valid = 1):
  - Register N full-precision signed products p[i] = x[i]*w[i], each 2*DATA_WIDTH bits.
  - Register the valid bit.
- Stage 2 (next edge):
  - Sign-extend each product to ACC_WIDTH.
  - Sum all products with a balanced adder tree; odd operands at any tree level pass through unchanged.
  - Register the sum into out and the valid bit into out_valid.
- Latency and throughput:
  - A pair presented at edge k appears on out with out_valid = 1 after edge k+2.
  - Throughput is one pair per cycle; back-to-back inputs give back-to-back outputs with no bubbles.
- in_valid = 0:
  - Stage registers for data hold their previous value.
  - The valid bit shifts 0, so out_valid drops after 2 cycles while out retains the last valid result.
- Arithmetic:
  - Two's-complement throughout.
  - Sum overflow beyond ACC_WIDTH wraps modulo 2^ACC_WIDTH; no saturation and no overflow flag.
  - With defaults, overflow is impossible: the worst case is 4 * 16384 = 65536.
- N = 1: out = x[0]*w[0] sign-extended; same 2-cycle latency.
- Reset mid-operation: all in-flight results are discarded; out_valid stays 0 until 2 edges after the first in_valid following release.
- No X propagation: out_valid is never X after reset.
- Purely synchronous datapath; the only asynchronous path is rst_n.

Test Plan:
- x={1,2,3,4}, w={5,6,7,8}, in_valid=1 one cycle -> out=70 (0x46), out_valid=1 exactly 2 cycles later, then out_valid=0.
- x={-1,-2,3,4}, w={5,6,-7,8} -> out=-6 (0xFFFFFFFA).
- Extremes:
  - x all -128, w all -128 -> out=65536 (0x10000).
  - x all -128, w all 127 -> out=-65024.
- Streaming: back-to-back pairs
  - {1,1,1,1}·{1,1,1,1}
  - {0,0,0,0}·{9,9,9,9}
  - {2,0,0,0}·{3,0,0,0}
  - Required response: out = 4, 0, 6 on consecutive cycles with out_valid high for 3 cycles.
- Reset mid-stream: assert rst_n=0 between clock edges while a result is in flight -> out=0 and out_valid=0 immediately; after release, no stale result appears.
- Zero vectors or in_valid=0 gaps: out holds the last valid value while out_valid=0; x={0,0,0,0} with valid -> out=0, out_valid=1.
